// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : MEM-stage data-memory handshake for word, byte and indirect
//            accesses. Stalls the upstream pipeline until the access completes.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  mem_byte_in,
    input  logic                  indirect_in,
    input  logic [DATA_WIDTH-1:0] alu_in,
    input  logic [DATA_WIDTH-1:0] sr2_in,
    input  logic                  dmem_resp,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  dmem_read,
    output logic                  dmem_write,
    output logic [DATA_WIDTH-1:0] dmem_address,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [1:0]            dmem_byte_en,
    output logic [DATA_WIDTH-1:0] mdr_out,
    output logic                  stall_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_PTR  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [DATA_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0] r_mdr;

    logic                  w_req;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_byte_fmt;
    logic                  w_ptr_load;
    logic                  w_final;
    logic                  w_mdr_load;
    logic [DATA_WIDTH-1:0] w_fmt;

    assign w_req = mem_read_in | mem_write_in;
    // An illegal read+write request is resolved as a read.
    assign w_rd  = mem_read_in;
    assign w_wr  = mem_write_in & ~mem_read_in;

    // Byte formatting only applies to the single access of LDB; pointer-stage reads are words.
    assign w_byte_fmt = mem_byte_in & ~indirect_in & (r_state != S_PTR);
    assign w_fmt      = w_byte_fmt ? {8'h00, (alu_in[0] ? dmem_rdata[15:8] : dmem_rdata[7:0])}
                                   : dmem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (dmem_resp) begin
                        w_next = indirect_in ? S_PTR : S_IDLE;
                    end else begin
                        w_next = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (dmem_resp) begin
                    w_next = indirect_in ? S_PTR : S_IDLE;
                end
            end
            S_PTR: begin
                if (dmem_resp) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_address = '0;
        dmem_wdata   = '0;
        dmem_byte_en = 2'b00;
        w_ptr_load   = 1'b0;
        w_final      = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE, S_ACC: begin
                    if (w_req || (r_state == S_ACC)) begin
                        dmem_address = alu_in;
                        if (indirect_in) begin
                            // Pointer fetch is a word read for both LDI and STI.
                            dmem_read    = 1'b1;
                            dmem_byte_en = 2'b11;
                            w_ptr_load   = dmem_resp;
                        end else begin
                            dmem_read  = w_rd;
                            dmem_write = w_wr;
                            if (mem_byte_in) begin
                                dmem_byte_en = alu_in[0] ? 2'b10 : 2'b01;
                                dmem_wdata   = {sr2_in[7:0], sr2_in[7:0]};
                            end else begin
                                dmem_byte_en = 2'b11;
                                dmem_wdata   = sr2_in;
                            end
                            w_final = dmem_resp;
                        end
                    end
                end
                S_PTR: begin
                    dmem_address = r_ptr;
                    dmem_read    = w_rd;
                    dmem_write   = w_wr;
                    dmem_byte_en = 2'b11;
                    dmem_wdata   = sr2_in;
                    w_final      = dmem_resp;
                end
                default: ;
            endcase
        end
        w_mdr_load = w_final & w_rd;
        stall_out  = (w_req | (r_state != S_IDLE)) & ~w_final & ~reset;
        mdr_out    = w_mdr_load ? w_fmt : r_mdr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_mdr <= '0;
        end else begin
            if (w_ptr_load) begin
                r_ptr <= dmem_rdata;
            end
            if (w_mdr_load) begin
                r_mdr <= w_fmt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Scoreboard bench for mem_access_ctrl with a word/byte memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        mem_read_in, mem_write_in, mem_byte_in, indirect_in;
    logic [15:0] alu_in, sr2_in;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_read, dmem_write;
    logic [15:0] dmem_address, dmem_wdata, mdr_out;
    logic [1:0]  dmem_byte_en;
    logic        stall_out;

    mem_access_ctrl #(.DATA_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_byte_in(mem_byte_in), .indirect_in(indirect_in),
        .alu_in(alu_in), .sr2_in(sr2_in),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_byte_en(dmem_byte_en), .mdr_out(mdr_out), .stall_out(stall_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic        final_acc;
        logic [15:0] mdr;
        int          stall;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem [logic [14:0]];
    logic [15:0] ref_mdr;
    logic [15:0] held_mdr;
    logic        mon_en;
    logic        in_txn;
    int          stall_cnt;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [15:0] mrd(input logic [15:0] a);
        if (mem.exists(a[15:1])) return mem[a[15:1]];
        return {1'b0, a[15:1]} ^ 16'hA5C3;
    endfunction

    task automatic mwr(input logic [15:0] a, input logic [1:0] be, input logic [15:0] d);
        logic [15:0] old;
        old = mrd(a);
        mem[a[15:1]] = {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
    endtask

    task automatic push(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [1:0] be, input logic [15:0] wd, input logic fin,
                        input logic [15:0] mdr, input int stall);
        exp_t e;
        e.rd = rd; e.wr = wr; e.addr = addr; e.be = be; e.wdata = wd;
        e.final_acc = fin; e.mdr = mdr; e.stall = stall;
        exp_q.push_back(e);
    endtask

    task automatic resp_after(input int w, input logic [15:0] data);
        repeat (w) begin @(posedge clk); #1; end
        dmem_rdata = data;
        dmem_resp  = 1'b1;
        @(posedge clk); #1;
        dmem_resp  = 1'b0;
        dmem_rdata = 16'($urandom);
    endtask

    // kind: 0 LDR, 1 STR, 2 LDB, 3 STB, 4 LDI, 5 STI. Called and returns at posedge+1.
    task automatic run_txn(input int kind, input logic [15:0] alu_a, input logic [15:0] sr2,
                           input int w1, input int w2);
        logic        ld, byt, ind;
        logic [15:0] alu, ptr, r1, r2;
        logic [1:0]  be;
        alu = alu_a;
        ld  = (kind == 0) || (kind == 2) || (kind == 4);
        byt = (kind == 2) || (kind == 3);
        ind = (kind >= 4);
        if (!byt) alu[0] = 1'b0;
        r1 = 16'($urandom);
        r2 = 16'($urandom);
        if (ind) begin
            ptr = mrd(alu);
            r1  = ptr;
            push(1'b1, 1'b0, alu, 2'b11, 16'h0, 1'b0, 16'h0, 0);
            if (ld) begin
                r2      = mrd(ptr);
                ref_mdr = r2;
                push(1'b1, 1'b0, ptr, 2'b11, 16'h0, 1'b1, ref_mdr, w1 + w2 + 1);
            end else begin
                push(1'b0, 1'b1, ptr, 2'b11, sr2, 1'b1, ref_mdr, w1 + w2 + 1);
                mwr(ptr, 2'b11, sr2);
            end
        end else begin
            be = byt ? (alu[0] ? 2'b10 : 2'b01) : 2'b11;
            if (ld) begin
                r1      = mrd(alu);
                ref_mdr = byt ? {8'h00, (alu[0] ? r1[15:8] : r1[7:0])} : r1;
                push(1'b1, 1'b0, alu, be, 16'h0, 1'b1, ref_mdr, w1);
            end else begin
                push(1'b0, 1'b1, alu, be, byt ? {sr2[7:0], sr2[7:0]} : sr2, 1'b1, ref_mdr, w1);
                mwr(alu, be, byt ? {sr2[7:0], sr2[7:0]} : sr2);
            end
        end
        mem_read_in  = ld;
        mem_write_in = !ld;
        mem_byte_in  = byt;
        indirect_in  = ind;
        alu_in       = alu;
        sr2_in       = sr2;
        in_txn       = 1'b1;
        resp_after(w1, r1);
        if (ind) resp_after(w2, r2);
        in_txn       = 1'b0;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
    endtask

    exp_t m_e;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("excl", {63'h0, dmem_read & dmem_write}, 64'h0);
            if (in_txn) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_access", 64'h1, 64'h0);
                end else begin
                    m_e = exp_q[0];
                    chk("access", {28'h0, dmem_read, dmem_write, dmem_address, dmem_byte_en,
                                   (m_e.wr ? dmem_wdata : 16'h0)},
                                  {28'h0, m_e.rd, m_e.wr, m_e.addr, m_e.be,
                                   (m_e.wr ? m_e.wdata : 16'h0)});
                    if (stall_out) stall_cnt++;
                    if (dmem_resp) begin
                        void'(exp_q.pop_front());
                        if (m_e.final_acc) begin
                            chk("stall_end", {63'h0, stall_out}, 64'h0);
                            chk("mdr", {48'h0, mdr_out}, {48'h0, m_e.mdr});
                            chk("stall_cnt", 64'(stall_cnt), 64'(m_e.stall));
                            held_mdr  = m_e.mdr;
                            stall_cnt = 0;
                        end
                    end
                end
            end else begin
                chk("idle", {45'h0, dmem_read, dmem_write, stall_out, mdr_out},
                            {45'h0, 1'b0, 1'b0, 1'b0, held_mdr});
            end
        end
    end

    initial begin
        n_tests = 0; n_fail = 0; stall_cnt = 0;
        mon_en = 1'b0; in_txn = 1'b0;
        ref_mdr = 16'h0; held_mdr = 16'h0;
        reset = 1'b1;
        mem_read_in = 1'b1; mem_write_in = 1'b0; mem_byte_in = 1'b0; indirect_in = 1'b0;
        alu_in = 16'h1234; sr2_in = 16'h0; dmem_resp = 1'b1; dmem_rdata = 16'hFFFF;
        #2;
        chk("rst_out", {29'h0, dmem_read, dmem_write, stall_out, dmem_address, mdr_out},
                       64'h0);
        mem_read_in = 1'b0; dmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        mem[15'(16'h1000 >> 1)] = 16'hBEEF;
        mem[15'(16'h3003 >> 1)] = 16'h7F80;
        mem[15'(16'h4000 >> 1)] = 16'h5000;
        mem[15'(16'h5000 >> 1)] = 16'h1234;
        run_txn(0, 16'h1000, 16'h0000, 2, 0);
        run_txn(3, 16'h2001, 16'h00A5, 0, 0);
        run_txn(2, 16'h3003, 16'h0000, 1, 0);
        run_txn(4, 16'h4000, 16'h0000, 1, 2);
        mem[15'(16'h4000 >> 1)] = 16'h6000;
        run_txn(5, 16'h4000, 16'hCAFE, 0, 1);
        chk("sti_mem", {48'h0, mrd(16'h6000)}, {48'h0, 16'hCAFE});

        // Reset while the LDI second access is outstanding.
        @(posedge clk); #1;
        mon_en = 1'b0;
        mem_read_in = 1'b1; indirect_in = 1'b1; mem_byte_in = 1'b0; alu_in = 16'h4000;
        dmem_rdata = 16'h5000; dmem_resp = 1'b1;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        #1;
        chk("ptr_state", {47'h0, dmem_read, dmem_address}, {47'h0, 1'b1, 16'h5000});
        reset = 1'b1;
        #1;
        chk("rst_ptr", {29'h0, dmem_read, dmem_write, stall_out, dmem_address, mdr_out},
                       64'h0);
        @(posedge clk); #1;
        mem_read_in = 1'b0; indirect_in = 1'b0;
        reset = 1'b0; dmem_resp = 1'b1; dmem_rdata = 16'hDEAD;
        @(negedge clk);
        chk("stale_resp", {45'h0, dmem_read, dmem_write, stall_out, mdr_out}, 64'h0);
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        @(negedge clk);
        chk("post_rst", {45'h0, dmem_read, dmem_write, stall_out, mdr_out}, 64'h0);
        @(posedge clk); #1;
        ref_mdr = 16'h0; held_mdr = 16'h0; stall_cnt = 0;
        mon_en = 1'b1;
        run_txn(0, 16'h1000, 16'h0000, 0, 0);

        for (int i = 0; i < 300; i++) begin
            run_txn($urandom_range(0, 5), 16'($urandom_range(0, 255)), 16'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        repeat (3) @(posedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
